// File: rtl/half_adder.sv
// Multi-lane half adder with a combinational sum/carry path and a registered copy qualified by in_valid.
// Optional carry-event counter (carry_cnt) is built only when HALF_ADDER_STATS_EN is defined.
module half_adder #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic [WIDTH-1:0] sum_q,
   output logic [WIDTH-1:0] carry_q,
   output logic             out_valid
`ifdef HALF_ADDER_STATS_EN
   ,
   output logic [CNT_W-1:0] carry_cnt
`endif
);

   // Lanes are fully independent: bitwise ops, no carry chain between bits.
   always_comb begin
      sum   = in1 ^ in2;
      carry = in1 & in2;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q     <= '0;
         carry_q   <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum_q   <= sum;
            carry_q <= carry;
         end
      end
   end

`ifdef HALF_ADDER_STATS_EN
   // Saturating count of accepted inputs that produced at least one carry bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         carry_cnt <= '0;
      end else if (in_valid && (|carry) && !(&carry_cnt)) begin
         carry_cnt <= carry_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed self-checking bench for half_adder: a 1-lane instance for the truth table and a
// 4-lane instance (CNT_W=4) for the registered path, reset priority and the optional counter.
module tb_half_adder;

   logic       clk;
   logic       rst;

   logic [0:0] a1, b1, sum1, carry1, sum_q1, carry_q1;
   logic       v1, ov1;

   logic [3:0] a4, b4, sum4, carry4, sum_q4, carry_q4;
   logic       v4, ov4;

`ifdef HALF_ADDER_STATS_EN
   logic [15:0] cnt1;
   logic [3:0]  cnt4;
`endif

   int checks;
   int failures;

   half_adder #(.WIDTH(1), .CNT_W(16)) u_ha1 (
      .clk(clk), .rst(rst), .in1(a1), .in2(b1), .in_valid(v1),
      .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1), .out_valid(ov1)
`ifdef HALF_ADDER_STATS_EN
      , .carry_cnt(cnt1)
`endif
   );

   half_adder #(.WIDTH(4), .CNT_W(4)) u_ha4 (
      .clk(clk), .rst(rst), .in1(a4), .in2(b4), .in_valid(v4),
      .sum(sum4), .carry(carry4), .sum_q(sum_q4), .carry_q(carry_q4), .out_valid(ov4)
`ifdef HALF_ADDER_STATS_EN
      , .carry_cnt(cnt4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge so registered outputs have settled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reg4(input string tag, input logic [3:0] es, input logic [3:0] ec,
                             input logic eov);
      chk({tag, "_sum_q"},   64'(sum_q4),   64'(es));
      chk({tag, "_carry_q"}, 64'(carry_q4), 64'(ec));
      chk({tag, "_out_valid"}, 64'(ov4),    64'(eov));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b1;
      v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      v4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
      step();
      step();

      check_reg4("reset", 4'h0, 4'h0, 1'b0);
      chk("reset_ov1", 64'(ov1), 64'(1'b0));

      // Truth table on the 1-lane instance, held in reset to show the comb path ignores rst.
      a1 = 1'b0; b1 = 1'b0; #10;
      chk("tt00_sum", 64'(sum1), 64'(1'b0)); chk("tt00_carry", 64'(carry1), 64'(1'b0));
      a1 = 1'b0; b1 = 1'b1; #10;
      chk("tt01_sum", 64'(sum1), 64'(1'b1)); chk("tt01_carry", 64'(carry1), 64'(1'b0));
      a1 = 1'b1; b1 = 1'b0; #10;
      chk("tt10_sum", 64'(sum1), 64'(1'b1)); chk("tt10_carry", 64'(carry1), 64'(1'b0));
      a1 = 1'b1; b1 = 1'b1; #10;
      chk("tt11_sum", 64'(sum1), 64'(1'b0)); chk("tt11_carry", 64'(carry1), 64'(1'b1));

      a4 = 4'b1100; b4 = 4'b1010; #1;
      chk("comb4_sum",   64'(sum4),   64'(4'b0110));
      chk("comb4_carry", 64'(carry4), 64'(4'b1000));

      // Reset wins over a simultaneous valid input.
      step();
      a4 = 4'b1111; b4 = 4'b1111; v4 = 1'b1;
      step();
      check_reg4("rst_prio", 4'h0, 4'h0, 1'b0);
      chk("rst_comb_sum",   64'(sum4),   64'(4'b0000));
      chk("rst_comb_carry", 64'(carry4), 64'(4'b1111));
`ifdef HALF_ADDER_STATS_EN
      chk("rst_prio_cnt", 64'(cnt4), 64'(4'd0));
`endif

      rst = 1'b0; v4 = 1'b0;
      step();
      check_reg4("idle", 4'h0, 4'h0, 1'b0);

      // Single valid transaction, then hold.
      a4 = 4'b1100; b4 = 4'b1010; v4 = 1'b1;
      step();
      check_reg4("single", 4'b0110, 4'b1000, 1'b1);
      a4 = 4'b0011; b4 = 4'b0011; v4 = 1'b0;
      step();
      check_reg4("single_hold", 4'b0110, 4'b1000, 1'b0);

      // Back-to-back valid inputs: one result per cycle.
      a4 = 4'b0101; b4 = 4'b0011; v4 = 1'b1;
      step();
      check_reg4("b2b0", 4'b0110, 4'b0001, 1'b1);
      a4 = 4'b1111; b4 = 4'b0001;
      step();
      check_reg4("b2b1", 4'b1110, 4'b0001, 1'b1);
      a4 = 4'b0000; b4 = 4'b0000;
      step();
      check_reg4("b2b2", 4'b0000, 4'b0000, 1'b1);
      v4 = 1'b0; a4 = 4'b1010; b4 = 4'b1010;
      step();
      check_reg4("b2b_end", 4'b0000, 4'b0000, 1'b0);

      // Alternating valid with changing operands.
      a4 = 4'b1001; b4 = 4'b0001; v4 = 1'b1;
      step();
      check_reg4("alt0", 4'b1000, 4'b0001, 1'b1);
      a4 = 4'b1111; b4 = 4'b1111; v4 = 1'b0;
      step();
      check_reg4("alt1", 4'b1000, 4'b0001, 1'b0);
      a4 = 4'b0110; b4 = 4'b0100; v4 = 1'b1;
      step();
      check_reg4("alt2", 4'b0010, 4'b0100, 1'b1);
      a4 = 4'b0001; b4 = 4'b0001; v4 = 1'b0;
      step();
      check_reg4("alt3", 4'b0010, 4'b0100, 1'b0);

      // Mid-run reset clears held results; first valid afterwards shows up one cycle later.
      rst = 1'b1; a4 = 4'b1111; b4 = 4'b1111; v4 = 1'b1;
      step();
      check_reg4("midrst", 4'h0, 4'h0, 1'b0);
      rst = 1'b0; a4 = 4'b0011; b4 = 4'b0001; v4 = 1'b1;
      step();
      check_reg4("post_rst", 4'b0010, 4'b0001, 1'b1);
      v4 = 1'b0;
      step();

`ifdef HALF_ADDER_STATS_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("cnt_clear", 64'(cnt4), 64'(4'd0));
      a4 = 4'b0001; b4 = 4'b0000; v4 = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("cnt_nocarry", 64'(cnt4), 64'(4'd0));
      a4 = 4'b1111; b4 = 4'b1111; v4 = 1'b0;
      for (int i = 0; i < 2; i++) step();
      chk("cnt_invalid", 64'(cnt4), 64'(4'd0));
      a4 = 4'b0001; b4 = 4'b0001; v4 = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("cnt_5", 64'(cnt4), 64'(4'd5));
      for (int i = 0; i < 10; i++) step();
      chk("cnt_15", 64'(cnt4), 64'(4'd15));
      for (int i = 0; i < 5; i++) step();
      chk("cnt_sat", 64'(cnt4), 64'(4'd15));
      a4 = 4'b0001; b4 = 4'b0000;
      for (int i = 0; i < 3; i++) step();
      chk("cnt_sat_nocarry", 64'(cnt4), 64'(4'd15));
      v4 = 1'b0;
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter: WIDTH, default 1, number of independent half-adder bit lanes (legal 1..64).
REQ-002 Parameter: CNT_W, default 16, width of the carry-event counter (legal 4..32).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: in1  input  WIDTH  first operand vector.
REQ-006 Port: in2  input  WIDTH  second operand vector.
REQ-007 Port: in_valid  input  1  qualifies in1/in2 for the registered path.
REQ-008 Port: sum  output  WIDTH  combinational per-lane sum.
REQ-009 Port: carry  output  WIDTH  combinational per-lane carry.
REQ-010 Port: sum_q  output  WIDTH  registered sum.
REQ-011 Port: carry_q  output  WIDTH  registered carry.
REQ-012 Port: out_valid  output  1  sum_q/carry_q hold a newly captured result.
REQ-013 Port: carry_cnt  output  CNT_W  carry-event count (present only with HALF_ADDER_STATS_EN).

Function
REQ-014 sum SHALL equal in1 XOR in2 per lane, zero latency, independent of clk, rst, in_valid.
REQ-015 carry SHALL equal in1 AND in2 per lane, zero latency, independent of clk, rst, in_valid.
REQ-016 Lanes SHALL be independent; no carry propagates between lanes.
REQ-017 On a rising edge with in_valid=1 and rst=0, sum_q/carry_q SHALL load the current sum/carry; out_valid SHALL be 1 in the following cycle (latency 1).
REQ-018 On a rising edge with in_valid=0 and rst=0, sum_q/carry_q SHALL hold; out_valid SHALL be 0.
REQ-019 Back-to-back in_valid SHALL yield one result per cycle, no bubbles, no backpressure.
REQ-020 X/unknown on in_valid is not handled; bench SHALL drive known values.

Reset
REQ-021 With rst=1 at a rising edge: sum_q=0, carry_q=0, out_valid=0, carry_cnt=0.
REQ-022 rst SHALL take priority over in_valid in the same cycle; the concurrent input is discarded.
REQ-023 rst SHALL not affect sum/carry combinational outputs.
REQ-024 After rst deasserts, the first valid input SHALL produce out_valid one cycle later.

Configuration
REQ-025 Macro HALF_ADDER_STATS_EN: when defined, carry_cnt exists and increments by 1 on each rising edge with rst=0, in_valid=1 and any carry bit set; saturates at 2^CNT_W-1 (no wrap).
REQ-026 Without HALF_ADDER_STATS_EN, the carry_cnt port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 WIDTH=1, in1/in2 = 00, 01, 10, 11 (10 time units each) -> sum/carry = 0/0, 1/0, 1/0, 0/1 immediately.
REQ-028 WIDTH=4, in1=4'b1100, in2=4'b1010, in_valid=1 one cycle -> next cycle sum_q=4'b0110, carry_q=4'b1000, out_valid=1; following cycle out_valid=0, values held.
REQ-029 rst=1 and in_valid=1 same edge with in1=in2=all-ones -> sum_q=0, carry_q=0, out_valid=0, carry_cnt=0.
REQ-030 STATS_EN, CNT_W=4, 20 consecutive valid cycles of in1=in2=1 -> carry_cnt saturates at 15; valid cycles with in1=1, in2=0 do not increment.
REQ-031 Alternating in_valid 1/0 with changing operands -> out_valid toggles one cycle delayed, sum_q updates only after valid cycles.
